// File: rtl/uart_pkt_responder_if.sv
// uart_pkt_responder_if: UART byte, response and payload-stream signals of uart_pkt_responder.
// master is the responder side; slave is the UART/downstream side.
interface uart_pkt_responder_if;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_busy;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       m_last;
   logic       pkt_ok;
   logic       pkt_err;
   logic [7:0] drop_cnt;
   modport master (
      input  rx_ready, rx_data, tx_busy, m_ready,
      output tx_start, tx_data, m_data, m_valid, m_last, pkt_ok, pkt_err, drop_cnt
   );
   modport slave (
      output rx_ready, rx_data, tx_busy, m_ready,
      input  tx_start, tx_data, m_data, m_valid, m_last, pkt_ok, pkt_err, drop_cnt
   );
endinterface

// File: rtl/uart_pkt_responder.sv
// uart_pkt_responder: parses A5/LEN/payload/CHK packets from a UART, answers ACK/NAK, streams good payloads.
// Optional inter-byte timeout in the receive states is enabled by defining UART_PKT_TIMEOUT_EN.
module uart_pkt_responder #(
   parameter int MAX_LEN        = 16,
   parameter int TIMEOUT_CYCLES = 125000
) (
   input  logic                 clk,
   input  logic                 rst,
   uart_pkt_responder_if.master bus
);
   localparam int IW = $clog2(MAX_LEN + 1);
   localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
   localparam logic [7:0] SOF = 8'hA5;
   localparam logic [7:0] ACK = 8'h06;
   localparam logic [7:0] NAK = 8'h15;
   typedef enum logic [2:0] {IDLE, GET_LEN, GET_PAY, GET_CHK, RESP, DRAIN} state_t;
   state_t        state;
   logic          rx_q, cap, len_err, fire, tmo;
   logic [7:0]    len, rem, chk, resp, drop_cnt;
   logic [IW-1:0] idx;
   logic [AW-1:0] addr;
   logic [7:0]    mem [MAX_LEN];
   assign cap  = bus.rx_ready && !rx_q;
   assign addr = idx[AW-1:0];
   // The response must go out in the same cycle tx_busy is seen low, so it is decoded from state.
   assign fire          = state == RESP && !bus.tx_busy;
   assign bus.tx_start  = fire;
   assign bus.tx_data   = fire ? resp : 8'h00;
   assign bus.pkt_ok    = fire && resp == ACK;
   assign bus.pkt_err   = (fire && resp != ACK) || tmo;
   assign bus.m_valid   = state == DRAIN;
   assign bus.m_data    = bus.m_valid ? mem[addr] : 8'h00;
   assign bus.m_last    = bus.m_valid && 8'(idx) == len - 8'd1;
   assign bus.drop_cnt  = drop_cnt;
`ifdef UART_PKT_TIMEOUT_EN
   logic [31:0] tcnt;
   logic        rx_st;
   assign rx_st = state inside {GET_LEN, GET_PAY, GET_CHK};
   assign tmo   = rx_st && !cap && tcnt == 32'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) tcnt <= '0;
      else tcnt <= (cap || !rx_st) ? '0 : tcnt + 32'd1;
`else
   assign tmo = 1'b0;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= IDLE;
         rx_q     <= 1'b1;
         len      <= '0;
         rem      <= '0;
         chk      <= '0;
         resp     <= '0;
         idx      <= '0;
         len_err  <= 1'b0;
         drop_cnt <= '0;
      end else begin
         rx_q <= bus.rx_ready;
         if (cap && (state == RESP || state == DRAIN) && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
         if (tmo) state <= IDLE;
         else case (state)
            IDLE: if (cap && bus.rx_data == SOF) state <= GET_LEN;
            GET_LEN: if (cap) begin
               len     <= bus.rx_data;
               rem     <= bus.rx_data;
               chk     <= bus.rx_data;
               idx     <= '0;
               len_err <= bus.rx_data == 8'd0 || int'(bus.rx_data) > MAX_LEN;
               state   <= bus.rx_data == 8'd0 ? GET_CHK : GET_PAY;
            end
            GET_PAY: if (cap) begin
               chk <= chk ^ bus.rx_data;
               rem <= rem - 8'd1;
               if (!len_err) idx <= idx + IW'(1);
               if (rem == 8'd1) state <= GET_CHK;
            end
            GET_CHK: if (cap) begin
               resp  <= (bus.rx_data == chk && !len_err) ? ACK : NAK;
               state <= RESP;
            end
            RESP: if (!bus.tx_busy) begin
               state <= resp == ACK ? DRAIN : IDLE;
               idx   <= '0;
            end
            DRAIN: if (bus.m_ready) begin
               if (bus.m_last) state <= IDLE;
               else idx <= idx + IW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   always_ff @(posedge clk)
      if (state == GET_PAY && cap && !len_err) mem[addr] <= bus.rx_data;
endmodule

// File: doc/uart_pkt_responder.md
UART_PKT_RESPONDER -- requirements
Module: uart_pkt_responder

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16: maximum payload bytes per packet (1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 125000: inter-byte timeout in clk cycles (used only per REQ-030).
REQ-003 SHALL have ports, one per line:
  clk  in  1  system clock; single clock domain
  rst  in  1  asynchronous, active-high reset
  rx_ready  in  1  UART byte-received level; may stay high several cycles
  rx_data  in  8  received byte, valid while rx_ready=1
  tx_start  out  1  one-cycle request to UART transmitter
  tx_data  out  8  response byte, valid with tx_start
  tx_busy  in  1  UART transmitter busy
  m_data  out  8  payload byte out
  m_valid  out  1  payload byte valid
  m_ready  in  1  downstream accepts byte
  m_last  out  1  marks final payload byte, qualified by m_valid
  pkt_ok  out  1  one-cycle pulse: good packet ACKed
  pkt_err  out  1  one-cycle pulse: packet rejected or aborted
  drop_cnt  out  8  saturating count of bytes dropped while busy
REQ-004 SHALL use one clock, clk; reset rst SHALL be asynchronous and active-high.

Function
REQ-005 Byte capture SHALL occur only on the cycle where rx_ready=1 and rx_ready was 0 the previous cycle (rising edge); a held level SHALL yield one byte.
REQ-006 Packet format: SOF=0xA5, LEN, LEN payload bytes, CHK; CHK = XOR of LEN and all payload bytes.
REQ-007 States: IDLE, GET_LEN, GET_PAY, GET_CHK, RESP, DRAIN.
REQ-008 IDLE: byte 0xA5 -> GET_LEN; any other byte discarded silently, no drop_cnt change.
REQ-009 GET_LEN: captured byte stored as LEN, running XOR initialised to LEN, -> GET_PAY; LEN=0 or LEN>MAX_LEN flags length error, still -> GET_CHK (LEN=0) or GET_PAY with payload not stored (LEN>MAX_LEN), consuming LEN bytes.
REQ-010 GET_PAY: each byte XORed into checksum, written to buffer index 0..LEN-1 (if LEN valid); after LEN-th byte -> GET_CHK.
REQ-011 GET_CHK: byte compared to running XOR; -> RESP next cycle with response 0x06 (match and length valid) or 0x15 (otherwise).
REQ-012 RESP: tx_start=1 and tx_data=response for exactly one cycle, issued on first RESP cycle with tx_busy=0; then ACK -> DRAIN with pkt_ok pulse same cycle as tx_start, NAK -> IDLE with pkt_err pulse same cycle.
REQ-013 DRAIN: buffer bytes presented in order on m_data with m_valid=1; byte advances on m_valid&&m_ready; m_last=1 on byte LEN-1; after last transfer -> IDLE.
REQ-014 m_data/m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-015 Captured bytes in RESP or DRAIN SHALL be dropped; drop_cnt increments by 1, saturating at 255, never wraps.
REQ-016 Buffer: MAX_LEN x 8 storage; index counter width ceil(log2(MAX_LEN+1)); checksum 8-bit XOR, no carry.
REQ-017 0xA5 inside LEN/payload/CHK SHALL be treated as data, not resync.
REQ-018 Minimum latency: CHK byte edge cycle N -> RESP at N+1 -> tx_start at N+1 if tx_busy=0.

Reset
REQ-020 On rst=1, immediately: state IDLE, tx_start=0, tx_data=0, m_valid=0, m_last=0, m_data=0, pkt_ok=0, pkt_err=0, drop_cnt=0, checksum/index cleared, rx_ready edge history=1 (so a high level at release is not a byte).
REQ-021 Reset mid-packet or mid-DRAIN SHALL discard the packet with no response and no pkt_err.

Configuration
REQ-030 Macro UART_PKT_TIMEOUT_EN defined: in GET_LEN/GET_PAY/GET_CHK, a counter reset on each captured byte; reaching TIMEOUT_CYCLES without a byte -> IDLE, pkt_err pulse, no response byte sent.
REQ-031 Macro undefined: no timeout counter; receive states wait indefinitely; TIMEOUT_CYCLES ignored.

Verification
REQ-040 A5 03 11 22 33 CHK=0x03^0x11^0x22^0x33=0x03, m_ready=1 -> tx_data=0x06, pkt_ok=1, m_data 11,22,33 with m_last on 33.
REQ-041 A5 02 10 20 CHK=0x00 (bad, correct 0x32) -> tx_data=0x15, pkt_err=1, no m_valid.
REQ-042 A5 00 00 -> NAK 0x15; A5 with LEN=0x11 (MAX_LEN=16) plus 17 bytes plus CHK -> NAK, no m_valid.
REQ-043 Good 3-byte packet with m_ready=0, then 300 extra rx bytes -> m_valid held, m_data=0x11 stable, drop_cnt=255.
REQ-044 tx_busy=1 for 50 cycles on RESP entry -> tx_start asserted first cycle tx_busy=0, single pulse; rx_ready held high 20 cycles counts as one byte.
REQ-045 With UART_PKT_TIMEOUT_EN, TIMEOUT_CYCLES=100: A5 02 11 then silence -> pkt_err at 100 cycles after 0x11, state IDLE, no tx_start; rst mid-payload -> all outputs 0.
